qspi_slave_link: RTL and testbench

Pin-side receive/transmit stage that sits between the raw QSPI pads (io0, io1, ss, sclk) and the top-level application logic, all clocked on the divided system clock. It synchronises the asynchronous serial pins into the clk domain and runs as an SPI mode-0 slave, MSB first, single-lane (io0 = MOSI, io1 = MISO). It delivers received bytes through a small FIFO with a valid/ready handshake and accepts transmit bytes through a valid/ready handshake.

---
 rtl/qspi_slave_link.sv | 183 ++++++++++++++++++
 tb/tb_qspi_slave_link.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_slave_link.sv
// SPI mode-0 slave pin stage: synchronises sclk/ss/io0, shifts bytes MSB first,
// buffers received bytes in a small FIFO and serialises offered tx bytes on io1.
module qspi_slave_link #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RX_DEPTH    = 4,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_sclk,
  input  logic       io_ss,
  input  logic       io_io0,
  output logic       io_io1,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overflow,
  output logic       frame_active,
  output logic [7:0] byte_count
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(RX_DEPTH);

  localparam logic [1:0] S_WAIT_IDLE = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_ACTIVE    = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, io0_sync_q;
  logic sclk_rise_q, sclk_fall_q, ss_rise_q, ss_fall_q, prime_q;

  logic [1:0]  state_q, state_d;
  logic        frame_active_q, frame_active_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_count_q, byte_count_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        byte_done_q, byte_done_d;
  logic        push_q, push_d;
  logic        io1_q, io1_d;
  logic        overflow_q, overflow_d;
  logic        rx_valid_q, rx_valid_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [RX_DEPTH];

  logic        tx_load_c, pop_c, full_c, wr_en_c;
  logic [AW:0] level_c;

  // Pin synchronisers and registered edge strobes from the two oldest stages
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      io0_sync_q  <= '0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ss_rise_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
      prime_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], io_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], io_ss};
      io0_sync_q  <= {io0_sync_q[SYNC_STAGES-2:0], io_io0};
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
      ss_rise_q   <= ss_sync_q[SYNC_STAGES-2] & ~ss_sync_q[SYNC_STAGES-1];
      ss_fall_q   <= ~ss_sync_q[SYNC_STAGES-2] & ss_sync_q[SYNC_STAGES-1];
      prime_q     <= 1'b1;
    end
  end

  assign level_c = wr_ptr_q - rd_ptr_q;
  assign full_c  = (level_c == DEPTH_L);
  assign pop_c   = rx_valid_q & rx_ready;
  assign wr_en_c = push_q & (~full_c | pop_c);

  always_comb begin
    state_d        = state_q;
    frame_active_d = frame_active_q;
    bit_cnt_d      = bit_cnt_q;
    byte_count_d   = byte_count_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    byte_done_d    = byte_done_q;
    push_d         = 1'b0;
    tx_load_c      = 1'b0;
    overflow_d     = overflow_q | (push_q & full_c & ~pop_c);
    wr_ptr_d       = wr_en_c ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    rd_ptr_d       = pop_c ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    rx_valid_d     = (wr_ptr_d != rd_ptr_d);

    case (state_q)
      // prime_q skips the reset value of the ss chain so an open frame is not mistaken for idle
      S_WAIT_IDLE: if (prime_q && (&ss_sync_q)) state_d = S_IDLE;
      S_IDLE: begin
        if (ss_fall_q) begin
          state_d        = S_ACTIVE;
          frame_active_d = 1'b1;
          bit_cnt_d      = 3'd0;
          byte_count_d   = 8'd0;
          byte_done_d    = 1'b0;
          tx_load_c      = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ss_rise_q) begin
          state_d        = S_IDLE;
          frame_active_d = 1'b0;
          bit_cnt_d      = 3'd0;
          byte_done_d    = 1'b0;
        end else if (sclk_rise_q) begin
          rx_shift_d = {rx_shift_q[6:0], io0_sync_q[SYNC_STAGES-1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_d       = 1'b1;
            byte_count_d = byte_count_q + 8'd1;
            byte_done_d  = 1'b1;
          end
        end else if (sclk_fall_q) begin
          if (byte_done_q) begin
            tx_load_c   = 1'b1;
            byte_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase

    if (tx_load_c) tx_shift_d = tx_valid ? tx_data : IDLE_BYTE;
    io1_d = (state_d == S_ACTIVE) ? tx_shift_d[7] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_WAIT_IDLE;
      frame_active_q <= 1'b0;
      bit_cnt_q      <= 3'd0;
      byte_count_q   <= 8'd0;
      rx_shift_q     <= 8'd0;
      tx_shift_q     <= 8'd0;
      byte_done_q    <= 1'b0;
      push_q         <= 1'b0;
      io1_q          <= 1'b0;
      overflow_q     <= 1'b0;
      rx_valid_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      frame_active_q <= frame_active_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_count_q   <= byte_count_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      byte_done_q    <= byte_done_d;
      push_q         <= push_d;
      io1_q          <= io1_d;
      overflow_q     <= overflow_d;
      rx_valid_q     <= rx_valid_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  // FIFO storage; a write while full lands on the slot being popped this cycle
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
  end

  assign rx_data      = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_valid     = rx_valid_q;
  assign tx_ready     = tx_load_c & tx_valid;
  assign io_io1       = io1_q;
  assign rx_overflow  = overflow_q;
  assign frame_active = frame_active_q;
  assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_qspi_slave_link.sv
// Directed bench for qspi_slave_link: SPI master model at clk/16 with hand-computed expectations.
module tb_qspi_slave_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_sclk = 1'b0;
  logic       io_ss = 1'b1;
  logic       io_io0 = 1'b0;
  logic       io_io1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rx_overflow;
  logic       frame_active;
  logic [7:0] byte_count;

  int total = 0;
  int bad = 0;
  int tx_pulses = 0;

  qspi_slave_link #(
    .SYNC_STAGES(2),
    .RX_DEPTH(4),
    .IDLE_BYTE(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_sclk(io_sclk),
    .io_ss(io_ss),
    .io_io0(io_io0),
    .io_io1(io_io1),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_overflow(rx_overflow),
    .frame_active(frame_active),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_ready) tx_pulses <= tx_pulses + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift the top nbits of mosi out; miso collects io1 just before each rising sclk
  task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input bit pop_last,
                          output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      io_io0 = mosi[3'(7 - i)];
      #80;
      miso = {miso[6:0], io_io1};
      io_sclk = 1'b1;
      if (pop_last && (i == nbits - 1)) begin
        // one-cycle pop aligned with the FIFO push of this byte
        #30 rx_ready = 1'b1;
        #10 rx_ready = 1'b0;
        #40;
      end else begin
        #80;
      end
      io_sclk = 1'b0;
    end
  endtask

  task automatic frame_open();
    io_ss = 1'b0;
    #80;
  endtask

  task automatic frame_close();
    #80;
    io_ss = 1'b1;
    #100;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    #10;
    rx_ready = 1'b0;
    #10;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #30;
    reset = 1'b0;
    #50;
  endtask

  initial begin
    logic [7:0] m1, m2, dummy;
    int p0;

    #12;
    do_reset();
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_io1", 32'(io_io1), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_overflow", 32'(rx_overflow), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);

    // single byte A5, no tx offered -> MISO carries FF
    p0 = tx_pulses;
    frame_open();
    chk("a5_frame_open", 32'(frame_active), 32'd1);
    spi_xfer(8'hA5, 8, 1'b0, m1);
    #80;
    chk("a5_rx_valid", 32'(rx_valid), 32'd1);
    chk("a5_rx_data", 32'(rx_data), 32'hA5);
    chk("a5_byte_count", 32'(byte_count), 32'd1);
    chk("a5_miso_idle", 32'(m1), 32'hFF);
    io_ss = 1'b1;
    #100;
    chk("a5_frame_closed", 32'(frame_active), 32'd0);
    chk("a5_io1_closed", 32'(io_io1), 32'd0);
    chk("a5_no_tx_ready", 32'(tx_pulses - p0), 32'd0);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty", 32'(rx_valid), 32'd0);

    // tx byte 3C captured at ss fall, next byte falls back to FF
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    p0 = tx_pulses;
    frame_open();
    tx_valid = 1'b0;
    spi_xfer(8'h5A, 8, 1'b0, m1);
    spi_xfer(8'hC3, 8, 1'b0, m2);
    frame_close();
    chk("tx_miso_3c", 32'(m1), 32'h3C);
    chk("tx_miso_ff", 32'(m2), 32'hFF);
    chk("tx_ready_once", 32'(tx_pulses - p0), 32'd1);
    chk("tx_byte_count", 32'(byte_count), 32'd2);
    pop_chk("tx_pop0", 8'h5A);
    pop_chk("tx_pop1", 8'hC3);
    chk("tx_empty", 32'(rx_valid), 32'd0);

    // five bytes into a four-deep FIFO with no pops -> 05 dropped
    frame_open();
    for (int b = 1; b <= 5; b++) spi_xfer(8'(b), 8, 1'b0, dummy);
    frame_close();
    chk("ovf_flag", 32'(rx_overflow), 32'd1);
    chk("ovf_byte_count", 32'(byte_count), 32'd5);
    chk("ovf_rx_valid", 32'(rx_valid), 32'd1);
    pop_chk("ovf_pop1", 8'h01);
    pop_chk("ovf_pop2", 8'h02);
    pop_chk("ovf_pop3", 8'h03);
    pop_chk("ovf_pop4", 8'h04);
    chk("ovf_empty", 32'(rx_valid), 32'd0);
    chk("ovf_sticky", 32'(rx_overflow), 32'd1);

    do_reset();
    chk("rst2_overflow", 32'(rx_overflow), 32'd0);
    chk("rst2_rx_valid", 32'(rx_valid), 32'd0);

    // full FIFO with a pop on the push cycle of the fifth byte -> no drop
    frame_open();
    for (int b = 0; b < 4; b++) spi_xfer(8'h10 + 8'(b), 8, 1'b0, dummy);
    spi_xfer(8'h14, 8, 1'b1, dummy);
    frame_close();
    chk("fp_no_overflow", 32'(rx_overflow), 32'd0);
    chk("fp_byte_count", 32'(byte_count), 32'd5);
    pop_chk("fp_pop1", 8'h11);
    pop_chk("fp_pop2", 8'h12);
    pop_chk("fp_pop3", 8'h13);
    pop_chk("fp_pop4", 8'h14);
    chk("fp_empty", 32'(rx_valid), 32'd0);

    // partial byte discarded, next frame clean
    frame_open();
    spi_xfer(8'hB8, 5, 1'b0, dummy);
    frame_close();
    chk("part_no_push", 32'(rx_valid), 32'd0);
    chk("part_byte_count", 32'(byte_count), 32'd0);
    frame_open();
    spi_xfer(8'h81, 8, 1'b0, dummy);
    frame_close();
    chk("part_next_valid", 32'(rx_valid), 32'd1);
    chk("part_next_data", 32'(rx_data), 32'h81);
    chk("part_next_count", 32'(byte_count), 32'd1);
    pop_chk("part_pop", 8'h81);

    // reset mid-byte with ss low: the rest of that frame is ignored
    frame_open();
    spi_xfer(8'hE0, 3, 1'b0, dummy);
    do_reset();
    spi_xfer(8'h55, 8, 1'b0, dummy);
    #80;
    chk("rmid_inactive", 32'(frame_active), 32'd0);
    frame_close();
    chk("rmid_no_rx", 32'(rx_valid), 32'd0);
    chk("rmid_byte_count", 32'(byte_count), 32'd0);
    frame_open();
    spi_xfer(8'h3E, 8, 1'b0, dummy);
    frame_close();
    chk("rmid_next_valid", 32'(rx_valid), 32'd1);
    chk("rmid_next_data", 32'(rx_data), 32'h3E);
    chk("rmid_next_count", 32'(byte_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
